// File: rtl/button_debouncer_n.sv
// N-channel push-button debouncer: 2-FF sync, symmetric press/release filter, level + rise/fall pulses.
// Optional long-press pulse per channel when macro DEBOUNCE_LONGPRESS_EN is defined (btn_long tied 0 otherwise).
module button_debouncer_n #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 12_500_000,
  parameter int ACTIVE_LOW    = 0,
  parameter int LONG_CYCLES   = 125_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_long
);

  localparam int C_MAXC =
    (STABLE_CYCLES > LONG_CYCLES) ? STABLE_CYCLES : LONG_CYCLES;
  localparam int CNT_W = $clog2(C_MAXC + 1);

  localparam logic [CNT_W-1:0] C_STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  localparam logic [N_CH-1:0] C_POL =
    (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [N_CH-1:0] w_raw;

  assign w_raw = button ^ C_POL;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic             r_rs;
    logic             r_fl;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_done;

    assign w_diff = r_s2 ^ r_lvl;
    assign w_done = w_diff && (r_cnt == C_STB_LAST);

    // two-stage synchroniser for the asynchronous raw input
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_raw[ch];
        r_s2 <= r_s1;
      end
    end

    // stability counter: any agreeing sample restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // accepted level and single-cycle edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lvl <= 1'b0;
        r_rs  <= 1'b0;
        r_fl  <= 1'b0;
      end else begin
        r_rs <= w_done & r_s2;
        r_fl <= w_done & ~r_s2;
        if (w_done) begin
          r_lvl <= r_s2;
        end
      end
    end

    assign btn_level[ch] = r_lvl;
    assign btn_rise[ch]  = r_rs;
    assign btn_fall[ch]  = r_fl;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [CNT_W-1:0] C_LONG_LAST =
      CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_LONG_DONE =
      CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] r_hcnt;
    logic             r_long;

    // hold timer: parks one past the trigger so each press pulses once
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hcnt <= '0;
        r_long <= 1'b0;
      end else if (!r_lvl) begin
        r_hcnt <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= (r_hcnt == C_LONG_LAST);
        if (r_hcnt != C_LONG_DONE) begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end

    assign btn_long[ch] = r_long;
`else
    assign btn_long[ch] = 1'b0;
`endif

  end : g_ch

endmodule
